// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell walks the operands LSB first,
// carrying between cycles, behind a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy,
    output logic             done
);
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_next;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    assign acc_next = {fa_sum, acc[WIDTH-1:1]};

    // S/Cout are only written on the final bit so they hold the previous
    // result while a new addition is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= fa_cout;
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        S     <= acc_next;
                        Cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// One-bit full adder cell shared by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes A+B+Cin results into a
// queue, a negedge monitor pops them on each done pulse.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH:0] sum;
        int             c0;
    } op_t;

    op_t            sq[$];
    int             cyc      = 0;
    int             n_checks = 0;
    int             n_pass   = 0;
    logic [WIDTH:0] model_res = '0;
    bit             prev_done = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .S    (s),
        .Cout (cout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                      name, actual, expected, cyc);
    endtask

    // Waits for IDLE, presents operands with start, and records the accepted op.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input bit hold_start, output int c0_out);
        int  waited;
        op_t o;
        waited = 0;
        @(negedge clk);
        while ((busy || done) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("idle_before_start", {31'd0, busy | done}, 32'd0);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(posedge clk);
        #1;
        o.sum = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        o.c0  = cyc;
        sq.push_back(o);
        c0_out = cyc;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom);
        if (!hold_start) start = 1'b0;
    endtask

    // Monitor: S/Cout must always show the last completed result; busy must
    // be high exactly for the WIDTH cycles after an accepting edge.
    always @(negedge clk) begin
        op_t o;
        if (!rst_n) begin
            model_res = '0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                checkOutput("done_with_op_pending", {31'd0, sq.size() != 0}, 32'd1);
                checkOutput("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (sq.size() != 0) begin
                    o = sq.pop_front();
                    checkOutput("latency", cyc - o.c0, WIDTH);
                    model_res = o.sum;
                end
            end
            checkOutput("sum", {{(32-WIDTH){1'b0}}, s}, {{(32-WIDTH){1'b0}}, model_res[WIDTH-1:0]});
            checkOutput("cout", {31'd0, cout}, {31'd0, model_res[WIDTH]});
            checkOutput("busy", {31'd0, busy},
                        {31'd0, (sq.size() != 0) && ((cyc - sq[0].c0) < WIDTH)});
            prev_done = done;
        end
    end

    initial begin
        int c0;
        int last_c0;
        int waited;

        #1;
        checkOutput("reset_s", {24'd0, s}, 32'd0);
        checkOutput("reset_cout", {31'd0, cout}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, c0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, c0);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, c0);
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, c0);

        // start pulses and operand churn while the op is in flight
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, c0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b1;
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            cin   = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;

        // asynchronous reset part-way through an addition
        applyStimulus(8'h5A, 8'h3C, 1'b1, 1'b0, c0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sq.delete();
        #1;
        checkOutput("async_reset_s", {24'd0, s}, 32'd0);
        checkOutput("async_reset_cout", {31'd0, cout}, 32'd0);
        checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, c0);

        // start held high: one accept every WIDTH+2 cycles
        applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, last_c0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, c0);
            checkOutput("throughput", c0 - last_c0, WIDTH + 2);
            last_c0 = c0;
        end
        start = 1'b0;

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, c0);
        end

        waited = 0;
        while (sq.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain", sq.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
